// File: rtl/recon_pkg.sv
// Shared encodings for the bitstream staging allocator: response status codes,
// FSM states and the default allocation granularity.
package recon_pkg;

  localparam int ALIGN_LOG2_DEFAULT = 12;

  typedef enum logic [1:0] {
    RSP_NEW       = 2'd0,
    RSP_REUSE_HIT = 2'd1,
    RSP_FULL      = 2'd2,
    RSP_ZERO_MISS = 2'd3
  } rsp_status_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_UPD  = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

endpackage

// File: rtl/recon_bs_table_ram.sv
// Simple dual-port table RAM holding {addr, region_len, size} per bitstream ID.
// One write port, one registered read port (1-cycle read latency).
module recon_bs_table_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/recon_bs_alloc.sv
// Bitstream staging allocator: bump allocator over a staging region with a
// per-ID table of {valid, addr, region_len, size}, plus lookup and flush.
module recon_bs_alloc
  import recon_pkg::*;
#(
  parameter int              ADDR_WIDTH = 34,
  parameter int              ID_WIDTH   = 8,
  parameter longint unsigned MEM_BYTES  = 64'd1 << 30,
  parameter int              ALIGN_LOG2 = ALIGN_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [ID_WIDTH-1:0]   alloc_id,
  input  logic [31:0]           alloc_size,
  input  logic                  lkp_valid,
  output logic                  lkp_ready,
  input  logic [ID_WIDTH-1:0]   lkp_id,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [31:0]           rsp_size,
  output logic [1:0]            rsp_status,
  output logic                  rsp_is_lkp,
  input  logic                  flush
);

  localparam int          DEPTH      = 1 << ID_WIDTH;
  localparam int          NF_W       = ADDR_WIDTH + 1;
  localparam int          RLEN_W     = 33;
  localparam int          DW         = ADDR_WIDTH + RLEN_W + 32;
  localparam logic [63:0] ALIGN_MASK = (64'd1 << ALIGN_LOG2) - 64'd1;
  localparam logic [63:0] MEM_LIMIT  = 64'(MEM_BYTES);

  state_e              state, state_nxt;
  logic                run_q;
  logic                rr_lkp;
  logic                flush_pend;
  logic [DEPTH-1:0]    valid_q;
  logic [NF_W-1:0]     next_free;
  logic                req_lkp;
  logic [ID_WIDTH-1:0] req_id;
  logic [31:0]         req_size;

  logic grant_alloc, grant_lkp, idle_open, accept, flush_exec;

  logic                  ram_we;
  logic [DW-1:0]         ram_wdata, ram_rdata;
  logic [ADDR_WIDTH-1:0] ent_addr;
  logic [RLEN_W-1:0]     ent_rlen;
  logic [31:0]           ent_size;

  logic                  ent_valid, do_new, do_reuse;
  logic [63:0]           rlen64, sum64;
  rsp_status_e           upd_status;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic [31:0]           upd_size;

  assign ent_addr = ram_rdata[DW-1 -: ADDR_WIDTH];
  assign ent_rlen = ram_rdata[32 +: RLEN_W];
  assign ent_size = ram_rdata[31:0];

  // run_q keeps both readies low while reset is held and for one cycle after.
  always_comb begin
    grant_alloc = alloc_valid && (!rr_lkp || !lkp_valid);
    grant_lkp   = lkp_valid && !grant_alloc;
    idle_open   = run_q && (state == ST_IDLE) && !flush_pend && !flush;
    alloc_ready = idle_open && grant_alloc;
    lkp_ready   = idle_open && grant_lkp;
    accept      = alloc_ready || lkp_ready;
    flush_exec  = (state == ST_IDLE) && flush_pend;
  end

  assign rsp_valid = (state == ST_RSP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RD;
      ST_RD:   state_nxt = ST_UPD;
      ST_UPD:  state_nxt = ST_RSP;
      ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ent_valid  = valid_q[req_id];
    rlen64     = (64'(req_size) + ALIGN_MASK) & ~ALIGN_MASK;
    sum64      = 64'(next_free) + rlen64;
    do_new     = 1'b0;
    do_reuse   = 1'b0;
    upd_status = RSP_ZERO_MISS;
    upd_addr   = '0;
    upd_size   = '0;
    if (req_lkp) begin
      if (ent_valid) begin
        upd_status = RSP_REUSE_HIT;
        upd_addr   = ent_addr;
        upd_size   = ent_size;
      end
    end else if (req_size != 32'd0) begin
      if (ent_valid && (RLEN_W'(req_size) <= ent_rlen)) begin
        do_reuse   = 1'b1;
        upd_status = RSP_REUSE_HIT;
        upd_addr   = ent_addr;
        upd_size   = req_size;
      end else if (sum64 <= MEM_LIMIT) begin
        do_new     = 1'b1;
        upd_status = RSP_NEW;
        upd_addr   = next_free[ADDR_WIDTH-1:0];
        upd_size   = req_size;
      end else begin
        upd_status = RSP_FULL;
      end
    end
    ram_we    = (state == ST_UPD) && (do_new || do_reuse);
    ram_wdata = do_new ? {next_free[ADDR_WIDTH-1:0], RLEN_W'(rlen64), req_size}
                       : {ent_addr, ent_rlen, req_size};
  end

  // A flush that arrives while one is pending simply leaves the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      rr_lkp     <= 1'b0;
      flush_pend <= 1'b0;
      valid_q    <= '0;
      next_free  <= '0;
      req_lkp    <= 1'b0;
      req_id     <= '0;
      req_size   <= '0;
      rsp_addr   <= '0;
      rsp_size   <= '0;
      rsp_status <= '0;
      rsp_is_lkp <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        rr_lkp   <= ~rr_lkp;
        req_lkp  <= lkp_ready;
        req_id   <= lkp_ready ? lkp_id : alloc_id;
        req_size <= lkp_ready ? 32'd0 : alloc_size;
      end
      if (flush_exec)  flush_pend <= 1'b0;
      else if (flush)  flush_pend <= 1'b1;
      if (flush_exec) begin
        valid_q   <= '0;
        next_free <= '0;
      end else if ((state == ST_UPD) && do_new) begin
        valid_q[req_id] <= 1'b1;
        next_free       <= NF_W'(sum64);
      end
      if (state == ST_UPD) begin
        rsp_addr   <= upd_addr;
        rsp_size   <= upd_size;
        rsp_status <= upd_status;
        rsp_is_lkp <= req_lkp;
      end
    end
  end

  recon_bs_table_ram #(
    .AW(ID_WIDTH),
    .DW(DW)
  ) u_table_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(req_id),
    .wdata(ram_wdata),
    .raddr(req_id),
    .rdata(ram_rdata)
  );

endmodule

// File: doc/recon_bs_alloc.md
RECON_BS_ALLOC -- requirements
Module: recon_bs_alloc

Interface
REQ-001 Parameter ADDR_WIDTH, default 34, sets the byte-address width of the bitstream staging memory.
REQ-002 Parameter ID_WIDTH, default 8, sets the bitstream-ID width; the table has 2**ID_WIDTH entries.
REQ-003 Parameter MEM_BYTES, default 2**30, sets the staging region size in bytes, starting at address 0.
REQ-004 Parameter ALIGN_LOG2, default 12, sets the allocation granularity to 2**ALIGN_LOG2 bytes.
REQ-005 clk  in  1  Single clock for all logic.
REQ-006 rst_n  in  1  Reset, asynchronous assert, active-low.
REQ-007 alloc_valid  in  1  Allocation request valid.
REQ-008 alloc_ready  out  1  Allocation request accepted.
REQ-009 alloc_id  in  ID_WIDTH  Bitstream ID to allocate.
REQ-010 alloc_size  in  32  Bitstream size in bytes.
REQ-011 lkp_valid  in  1  Lookup request valid.
REQ-012 lkp_ready  out  1  Lookup request accepted.
REQ-013 lkp_id  in  ID_WIDTH  Bitstream ID to look up.
REQ-014 rsp_valid  out  1  Response valid.
REQ-015 rsp_ready  in  1  Response consumed.
REQ-016 rsp_addr  out  ADDR_WIDTH  Base address of the entry.
REQ-017 rsp_size  out  32  Size stored for the entry.
REQ-018 rsp_status  out  2  0=NEW, 1=REUSE/HIT, 2=FULL, 3=ZERO/MISS.
REQ-019 rsp_is_lkp  out  1  1 = response belongs to a lookup, 0 = response belongs to an allocation.
REQ-020 flush  in  1  Single-cycle pulse; invalidates all entries and rewinds the allocator.

Function
REQ-021 The FSM SHALL have four states: IDLE -> RD -> UPD -> RSP, and return to IDLE on rsp_valid&&rsp_ready.
REQ-022 alloc_ready and lkp_ready SHALL be high only in IDLE with no flush pending, and only for the granted requester; both SHALL never be high together.
REQ-023 Arbitration SHALL be round-robin; after reset the first grant goes to alloc, and the pointer toggles after each accepted request.
REQ-024 The table entry SHALL hold {valid, addr, region_len, size}; valid bits SHALL be flops and the other fields SHALL be a 1-cycle-read RAM, read in RD.
REQ-025 Response latency: a request accepted in cycle T SHALL give rsp_valid=1 in cycle T+3; rsp_valid and rsp_* SHALL be held stable until rsp_ready.
REQ-026 Alloc, size 0: status ZERO, addr=0, size=0, no table or pointer change.
REQ-027 Alloc with entry valid and alloc_size <= region_len: status REUSE, the stored addr is returned, only the size field is updated.
REQ-028 Alloc otherwise: rlen = alloc_size rounded up to 2**ALIGN_LOG2.
REQ-029 If next_free+rlen <= MEM_BYTES, the entry SHALL be written {1, next_free, rlen, alloc_size}, next_free SHALL advance by rlen, and status SHALL be NEW.
REQ-030 If the REQ-029 bound fails: status FULL, addr=0, nothing changes (any old entry stays valid).
REQ-031 next_free and the bound compare SHALL be ADDR_WIDTH+1 bits wide so overflow cannot wrap.
REQ-032 A superseded region is not reclaimed; space is reclaimed only by flush.
REQ-033 Lookup, valid entry: status HIT, stored addr and size returned.
REQ-034 Lookup, invalid entry: status MISS, addr=0, size=0.
REQ-035 flush SHALL latch a pending bit in any state; the pending bit SHALL block new accepts.
REQ-036 A pending flush SHALL execute in the first IDLE cycle: all valid bits cleared and next_free=0 in one cycle, then the pending bit clears.
REQ-037 An in-flight request SHALL complete, and respond, before the flush executes.
REQ-038 A flush pulse arriving while a flush is already pending SHALL merge with it.

Reset
REQ-039 On rst_n low, asynchronously: state=IDLE, all valid bits=0, next_free=0, rr pointer=alloc, flush pending=0, rsp_valid=0, rsp_addr/rsp_size/rsp_status/rsp_is_lkp=0, ready outputs=0 while in reset.
REQ-040 Reset mid-operation SHALL abort the request with no response; table RAM contents are don't-care because the valid bits are cleared.

Structure
REQ-041 A shared package recon_pkg SHALL hold the rsp_status encodings, the FSM state encoding and the ALIGN_LOG2 default.
REQ-042 The table RAM SHALL be one sub-module, recon_bs_table_ram (simple dual-port, 1-cycle read, write-first not required); arbitration and FSM logic stay inline.

Verification (ALIGN_LOG2=12, MEM_BYTES=65536)
REQ-043 Alloc id5/100, then id6/4097, then id7/1 -> NEW at 0x0000, 0x1000, 0x3000; latency exactly 3 cycles each.
REQ-044 After REQ-043: alloc id5/4000 -> REUSE addr 0x0000; then lkp id5 -> HIT addr 0x0000, size 4000; lkp id9 -> MISS, addr 0, size 0.
REQ-045 From reset: alloc id1/61440 -> NEW 0x0000; then alloc id2/8192 -> FULL; then alloc id2/4096 -> NEW 0xF000; then alloc id3/0 -> ZERO.
REQ-046 alloc_valid and lkp_valid asserted together from reset -> alloc granted first, lookup next; ready is never high for both at once; rsp_ready held low 5 cycles -> response held stable.
REQ-047 flush pulsed during UPD of alloc id4 -> the id4 NEW response is delivered, then lkp id4 -> MISS, next alloc -> addr 0x0000.
REQ-048 rst_n dropped in RD -> no response, rsp_valid=0 immediately, lkp of any ID -> MISS after release.
